// File: rtl/bubble_pkg.sv
// Shared types and default widths for the in-memory bubble sorter.
package bubble_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 16;

  typedef enum logic [2:0] {
    IDLE,
    RD_A,
    RD_B,
    WR_LO,
    WR_HI,
    DONE
  } sorter_state_t;

endpackage

// File: rtl/mem_bubble_sorter.sv
// In-place ascending unsigned bubble sort of a word region of the data memory.
// Uses the memory's combinational read port and synchronous write port.
// Every memory-facing output is registered and set on the transition into the
// state that needs it.
module mem_bubble_sorter #(
  parameter int ADDR_W = bubble_pkg::ADDR_W,
  parameter int DATA_W = bubble_pkg::DATA_W,
  parameter int CNT_W  = bubble_pkg::CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base,
  input  logic [CNT_W-1:0]  count,
  output logic              busy,
  output logic              done,
  output logic [31:0]       swaps,
  output logic [ADDR_W-1:0] read_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [ADDR_W-1:0] write_addr,
  output logic              write_en,
  output logic [DATA_W-1:0] data_in
);
  import bubble_pkg::*;

  sorter_state_t     state;
  logic [ADDR_W-1:0] base_q;
  logic [CNT_W-1:0]  idx;
  logic [CNT_W-1:0]  limit;
  logic [DATA_W-1:0] a_q;
  logic              swapped;

  logic [CNT_W-1:0]  idx_next;
  logic [ADDR_W-1:0] addr_lo;
  logic [ADDR_W-1:0] addr_hi;
  logic              more_pairs;
  logic              swapped_now;
  logic              finish_sort;

  sorter_state_t     adv_state;
  logic [CNT_W-1:0]  adv_idx;
  logic [CNT_W-1:0]  adv_limit;
  logic              adv_swapped;
  logic [ADDR_W-1:0] adv_read_addr;
  logic              adv_busy;
  logic              adv_done;

  // Pair addresses wrap modulo 2^ADDR_W; idx+1 cannot overflow since idx < limit.
  assign idx_next    = idx + CNT_W'(1);
  assign addr_lo     = base_q + ADDR_W'(idx);
  assign addr_hi     = addr_lo + ADDR_W'(1);
  assign more_pairs  = idx_next < limit;
  assign swapped_now = swapped | (state == WR_HI);
  assign finish_sort = !swapped_now || (limit == CNT_W'(1));

  // Pair-advance decision shared by the no-swap exit of RD_B and by WR_HI.
  always_comb begin
    adv_state     = RD_A;
    adv_idx       = idx;
    adv_limit     = limit;
    adv_swapped   = swapped_now;
    adv_read_addr = base_q + ADDR_W'(idx_next);
    adv_busy      = 1'b1;
    adv_done      = 1'b0;
    if (more_pairs) begin
      adv_idx = idx_next;
    end else if (finish_sort) begin
      adv_state     = DONE;
      adv_read_addr = base_q;
      adv_busy      = 1'b0;
      adv_done      = 1'b1;
    end else begin
      adv_limit     = limit - CNT_W'(1);
      adv_idx       = '0;
      adv_swapped   = 1'b0;
      adv_read_addr = base_q;
    end
  end

  // Sorter FSM with registered memory-port and status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      base_q     <= '0;
      idx        <= '0;
      limit      <= '0;
      a_q        <= '0;
      swapped    <= 1'b0;
      swaps      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      read_addr  <= '0;
      write_addr <= '0;
      write_en   <= 1'b0;
      data_in    <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            base_q    <= base;
            idx       <= '0;
            limit     <= count - CNT_W'(1);
            swaps     <= '0;
            swapped   <= 1'b0;
            read_addr <= base;
            if (count < CNT_W'(2)) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= RD_A;
              busy  <= 1'b1;
            end
          end
        end
        RD_A: begin
          a_q       <= mem_rdata;
          read_addr <= addr_hi;
          state     <= RD_B;
        end
        RD_B: begin
          if (a_q > mem_rdata) begin
            state      <= WR_LO;
            read_addr  <= base_q;
            write_en   <= 1'b1;
            write_addr <= addr_lo;
            data_in    <= mem_rdata;
          end else begin
            state     <= adv_state;
            idx       <= adv_idx;
            limit     <= adv_limit;
            swapped   <= adv_swapped;
            read_addr <= adv_read_addr;
            busy      <= adv_busy;
            done      <= adv_done;
          end
        end
        WR_LO: begin
          write_addr <= addr_hi;
          data_in    <= a_q;
          state      <= WR_HI;
        end
        WR_HI: begin
          write_en   <= 1'b0;
          write_addr <= '0;
          data_in    <= '0;
          swaps      <= swaps + 32'd1;
          state      <= adv_state;
          idx        <= adv_idx;
          limit      <= adv_limit;
          swapped    <= adv_swapped;
          read_addr  <= adv_read_addr;
          busy       <= adv_busy;
          done       <= adv_done;
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bubble_sorter.sv
// Directed self-checking bench for mem_bubble_sorter with a 32-word memory model.
module tb_mem_bubble_sorter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] base = '0;
  logic [15:0] count = '0;
  logic        busy;
  logic        done;
  logic [31:0] swaps;
  logic [31:0] read_addr;
  logic [31:0] mem_rdata;
  logic [31:0] write_addr;
  logic        write_en;
  logic [31:0] data_in;

  logic [31:0] mem [0:31];
  logic        tb_we = 1'b0;
  logic [4:0]  tb_waddr = '0;
  logic [31:0] tb_wdata = '0;
  int          wr_count = 0;
  logic [31:0] rd0, rd1;

  int tests_run = 0;
  int tests_failed = 0;

  mem_bubble_sorter dut (
    .clk(clk), .rst(rst), .start(start), .base(base), .count(count),
    .busy(busy), .done(done), .swaps(swaps), .read_addr(read_addr),
    .mem_rdata(mem_rdata), .write_addr(write_addr), .write_en(write_en),
    .data_in(data_in)
  );

  always #5 clk = ~clk;

  // Memory model: combinational read, synchronous write (sorter or bench loader).
  assign mem_rdata = mem[read_addr[4:0]];

  always @(posedge clk) begin
    if (write_en) begin
      mem[write_addr[4:0]] <= data_in;
      wr_count <= wr_count + 1;
    end else if (tb_we) begin
      mem[tb_waddr] <= tb_wdata;
    end
  end

  task automatic load_word(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    tb_we = 1'b1; tb_waddr = a; tb_wdata = d;
    @(posedge clk);
    #1 tb_we = 1'b0;
  endtask

  task automatic start_sort(input logic [31:0] b, input logic [15:0] c);
    @(negedge clk);
    start = 1'b1; base = b; count = c;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int busy_cycles, output bit timed_out);
    int n_busy;
    n_busy = 0;
    busy_cycles = 0;
    timed_out = 1'b1;
    for (int k = 0; k < 2000; k++) begin
      if (busy) begin
        if (n_busy == 0) rd0 = read_addr;
        if (n_busy == 1) rd1 = read_addr;
        n_busy++;
      end
      if (done) begin
        timed_out = 1'b0;
        break;
      end
      @(negedge clk);
    end
    busy_cycles = n_busy;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    tests_run++;
    if ({busy, done, write_en} !== 3'b000 || swaps !== 32'd0 || read_addr !== 32'd0 ||
        write_addr !== 32'd0 || data_in !== 32'd0) begin
      $display("[TB] FAIL reset_values busy=%b done=%b we=%b swaps=%0d ra=%h wa=%h di=%h, required all 0",
               busy, done, write_en, swaps, read_addr, write_addr, data_in);
      tests_failed++;
    end
    rst = 1'b0;
    @(negedge clk);
    tests_run++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      $display("[TB] FAIL idle_after_reset busy=%b done=%b, required 0 0", busy, done);
      tests_failed++;
    end
  endtask

  task automatic test_sort_basic();
    logic [31:0] exp [5];
    int bc, w0;
    bit to;
    exp = '{32'd9, 32'd18, 32'd29, 32'd76, 32'd100};
    load_word(0, 100); load_word(1, 29); load_word(2, 18); load_word(3, 76); load_word(4, 9);
    w0 = wr_count;
    start_sort(32'd0, 16'd5);
    wait_done(bc, to);
    tests_run++;
    if (to) begin $display("[TB] FAIL basic_timeout done never seen"); tests_failed++; end
    tests_run++;
    if (bc != 36) begin $display("[TB] FAIL basic_busy_cycles got %0d, required 36", bc); tests_failed++; end
    tests_run++;
    if (swaps !== 32'd8) begin $display("[TB] FAIL basic_swaps got %0d, required 8", swaps); tests_failed++; end
    tests_run++;
    if (wr_count - w0 != 16) begin $display("[TB] FAIL basic_writes got %0d, required 16", wr_count - w0); tests_failed++; end
    for (int k = 0; k < 5; k++) begin
      tests_run++;
      if (mem[k] !== exp[k]) begin
        $display("[TB] FAIL basic_word%0d got %0d, required %0d", k, mem[k], exp[k]);
        tests_failed++;
      end
    end
    @(negedge clk);
    tests_run++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      $display("[TB] FAIL basic_done_pulse done=%b busy=%b one cycle later, required 0 0", done, busy);
      tests_failed++;
    end
    tests_run++;
    if (swaps !== 32'd8) begin $display("[TB] FAIL basic_swaps_hold got %0d, required 8", swaps); tests_failed++; end
  endtask

  task automatic test_short_counts();
    logic [15:0] cnts [2];
    logic [31:0] bases [2];
    int w0;
    cnts = '{16'd1, 16'd0};
    bases = '{32'd8, 32'd12};
    for (int t = 0; t < 2; t++) begin
      w0 = wr_count;
      start_sort(bases[t], cnts[t]);
      tests_run++;
      if (done !== 1'b1 || busy !== 1'b0) begin
        $display("[TB] FAIL short%0d_done done=%b busy=%b, required 1 0", cnts[t], done, busy);
        tests_failed++;
      end
      tests_run++;
      if (read_addr !== bases[t] || write_en !== 1'b0 || swaps !== 32'd0) begin
        $display("[TB] FAIL short%0d_idle ra=%h we=%b swaps=%0d, required ra=%h we=0 swaps=0",
                 cnts[t], read_addr, write_en, swaps, bases[t]);
        tests_failed++;
      end
      @(negedge clk);
      tests_run++;
      if (done !== 1'b0 || read_addr !== bases[t] || wr_count != w0) begin
        $display("[TB] FAIL short%0d_after done=%b ra=%h writes=%0d, required 0 %h 0",
                 cnts[t], done, read_addr, wr_count - w0, bases[t]);
        tests_failed++;
      end
    end
  endtask

  task automatic test_sorted();
    int bc, w0;
    bit to;
    for (int k = 0; k < 5; k++) load_word(5'(16 + k), 32'(k + 1));
    w0 = wr_count;
    start_sort(32'd16, 16'd5);
    wait_done(bc, to);
    tests_run++;
    if (to) begin $display("[TB] FAIL sorted_timeout done never seen"); tests_failed++; end
    tests_run++;
    if (bc != 8) begin $display("[TB] FAIL sorted_busy_cycles got %0d, required 8", bc); tests_failed++; end
    tests_run++;
    if (swaps !== 32'd0 || wr_count != w0) begin
      $display("[TB] FAIL sorted_no_writes swaps=%0d writes=%0d, required 0 0", swaps, wr_count - w0);
      tests_failed++;
    end
    for (int k = 0; k < 5; k++) begin
      tests_run++;
      if (mem[16 + k] !== 32'(k + 1)) begin
        $display("[TB] FAIL sorted_word%0d got %0d, required %0d", k, mem[16 + k], k + 1);
        tests_failed++;
      end
    end
  endtask

  task automatic test_wrap();
    int bc;
    bit to;
    load_word(31, 32'hFFFF_FFFF);
    load_word(0, 32'd1);
    start_sort(32'hFFFF_FFFF, 16'd2);
    wait_done(bc, to);
    tests_run++;
    if (to) begin $display("[TB] FAIL wrap_timeout done never seen"); tests_failed++; end
    tests_run++;
    if (rd0 !== 32'hFFFF_FFFF || rd1 !== 32'h0000_0000) begin
      $display("[TB] FAIL wrap_read_addrs got %h %h, required ffffffff 00000000", rd0, rd1);
      tests_failed++;
    end
    tests_run++;
    if (mem[31] !== 32'd1 || mem[0] !== 32'hFFFF_FFFF) begin
      $display("[TB] FAIL wrap_result got %h %h, required 00000001 ffffffff", mem[31], mem[0]);
      tests_failed++;
    end
    tests_run++;
    if (swaps !== 32'd1 || bc != 4) begin
      $display("[TB] FAIL wrap_swaps swaps=%0d busy=%0d, required 1 4", swaps, bc);
      tests_failed++;
    end
  endtask

  task automatic test_start_while_busy();
    logic [31:0] exp [5];
    int bc;
    bit to;
    exp = '{32'd9, 32'd18, 32'd29, 32'd76, 32'd100};
    load_word(0, 100); load_word(1, 29); load_word(2, 18); load_word(3, 76); load_word(4, 9);
    for (int k = 0; k < 5; k++) load_word(5'(16 + k), 32'(5 - k));
    start_sort(32'd0, 16'd5);
    bc = 0;
    to = 1'b1;
    for (int k = 0; k < 2000; k++) begin
      if (busy) bc++;
      if (done) begin to = 1'b0; break; end
      start = (k == 3 || k == 4 || k == 17);
      base = 32'd16;
      count = 16'd3;
      @(negedge clk);
    end
    start = 1'b0;
    tests_run++;
    if (to) begin $display("[TB] FAIL busy_start_timeout done never seen"); tests_failed++; end
    tests_run++;
    if (bc != 36 || swaps !== 32'd8) begin
      $display("[TB] FAIL busy_start_ignored busy=%0d swaps=%0d, required 36 8", bc, swaps);
      tests_failed++;
    end
    for (int k = 0; k < 5; k++) begin
      tests_run++;
      if (mem[k] !== exp[k]) begin
        $display("[TB] FAIL busy_start_word%0d got %0d, required %0d", k, mem[k], exp[k]);
        tests_failed++;
      end
    end
    start_sort(32'd16, 16'd5);
    tests_run++;
    if (busy !== 1'b1 || swaps !== 32'd0) begin
      $display("[TB] FAIL restart_after_done busy=%b swaps=%0d, required 1 0", busy, swaps);
      tests_failed++;
    end
    wait_done(bc, to);
    tests_run++;
    if (to) begin $display("[TB] FAIL restart_timeout done never seen"); tests_failed++; end
    tests_run++;
    if (bc != 40 || swaps !== 32'd10) begin
      $display("[TB] FAIL restart_reverse busy=%0d swaps=%0d, required 40 10", bc, swaps);
      tests_failed++;
    end
    for (int k = 0; k < 5; k++) begin
      tests_run++;
      if (mem[16 + k] !== 32'(k + 1)) begin
        $display("[TB] FAIL restart_word%0d got %0d, required %0d", k, mem[16 + k], k + 1);
        tests_failed++;
      end
    end
  endtask

  task automatic test_reset_mid_write();
    int bc;
    bit to;
    load_word(0, 100); load_word(1, 29); load_word(2, 5);
    start_sort(32'd0, 16'd3);
    repeat (7) @(negedge clk);
    tests_run++;
    if (write_en !== 1'b1 || write_addr !== 32'd2 || data_in !== 32'd100 || swaps !== 32'd1) begin
      $display("[TB] FAIL midwr_state we=%b wa=%0d di=%0d swaps=%0d, required 1 2 100 1",
               write_en, write_addr, data_in, swaps);
      tests_failed++;
    end
    #1 rst = 1'b1;
    #1;
    tests_run++;
    if (write_en !== 1'b0 || busy !== 1'b0 || swaps !== 32'd0) begin
      $display("[TB] FAIL midwr_async_reset we=%b busy=%b swaps=%0d, required 0 0 0",
               write_en, busy, swaps);
      tests_failed++;
    end
    @(negedge clk);
    rst = 1'b0;
    tests_run++;
    if (mem[0] !== 32'd29 || mem[1] !== 32'd5 || mem[2] !== 32'd5) begin
      $display("[TB] FAIL midwr_partial got %0d %0d %0d, required 29 5 5", mem[0], mem[1], mem[2]);
      tests_failed++;
    end
    start_sort(32'd0, 16'd3);
    wait_done(bc, to);
    tests_run++;
    if (to) begin $display("[TB] FAIL midwr_resort_timeout done never seen"); tests_failed++; end
    tests_run++;
    if (mem[0] !== 32'd5 || mem[1] !== 32'd5 || mem[2] !== 32'd29 || swaps !== 32'd2 || bc != 10) begin
      $display("[TB] FAIL midwr_resort got %0d %0d %0d swaps=%0d busy=%0d, required 5 5 29 2 10",
               mem[0], mem[1], mem[2], swaps, bc);
      tests_failed++;
    end
  endtask

  initial begin
    test_reset();
    test_sort_basic();
    test_short_counts();
    test_sorted();
    test_wrap();
    test_start_while_busy();
    test_reset_mid_write();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
